// File: rtl/ysyx_25040129_ifu.sv
// Instruction fetch unit: owns the PC, issues one AXI-Lite read per instruction
// to the ICACHE and hands each fetched word to the IDU over valid/ready.
module ysyx_25040129_ifu #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ifu_araddr,
    output logic        ifu_arvalid,
    input  logic        ifu_arready,
    input  logic [31:0] ifu_rdata,
    input  logic [1:0]  ifu_rresp,
    input  logic        ifu_rvalid,
    output logic        ifu_rready,
    output logic        fence_i,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        fence_i_req
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_FENCE
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   araddr_q, araddr_d;
    logic [XLEN-1:0]   inst_q, inst_d;
    logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
    logic              fault_q, fault_d;
    logic              drop_q, drop_d;
    logic              pend_fence_q, pend_fence_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              ivalid_q, ivalid_d;
    logic              fence_q, fence_d;

    // Next-state, PC and payload computation
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        fault_d      = fault_q;
        drop_d       = drop_q;
        pend_fence_d = pend_fence_q;

        if (redirect_valid) begin
            pc_d         = redirect_pc;
            pend_fence_d = fence_i_req;
        end

        case (state_q)
            S_BOOT: state_d = pend_fence_d ? S_FENCE : S_REQ;
            S_REQ: begin
                if (arvalid_q) begin
                    // An issued address is never withdrawn; a redirect only marks it stale.
                    if (redirect_valid) drop_d = 1'b1;
                    if (ifu_arready)    state_d = S_WAIT;
                end else if (redirect_valid) begin
                    state_d = pend_fence_d ? S_FENCE : S_REQ;
                end else begin
                    // Misaligned PC: report a fault without touching the bus.
                    state_d   = S_OUT;
                    inst_d    = '0;
                    fault_d   = 1'b1;
                    inst_pc_d = pc_q;
                end
            end
            S_WAIT: begin
                if (ifu_rvalid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = pend_fence_d ? S_FENCE : S_REQ;
                    end else begin
                        inst_d    = ifu_rdata;
                        fault_d   = (ifu_rresp != 2'b00);
                        inst_pc_d = pc_q;
                        state_d   = S_OUT;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    state_d = pend_fence_d ? S_FENCE : S_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_REQ;
                end
            end
            S_FENCE: begin
                if (!redirect_valid) pend_fence_d = 1'b0;
                state_d = pend_fence_d ? S_FENCE : S_REQ;
            end
            default: state_d = S_BOOT;
        endcase
    end

    // Registered bus/handshake outputs decoded from the next state
    always_comb begin
        arvalid_d = (state_d == S_REQ) && (arvalid_q || (pc_d[1:0] == 2'b00));
        araddr_d  = arvalid_q ? araddr_q : pc_d;
        rready_d  = (state_d == S_WAIT);
        ivalid_d  = (state_d == S_OUT);
        fence_d   = (state_d == S_FENCE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            araddr_q     <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            fault_q      <= 1'b0;
            drop_q       <= 1'b0;
            pend_fence_q <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            ivalid_q     <= 1'b0;
            fence_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            araddr_q     <= araddr_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            fault_q      <= fault_d;
            drop_q       <= drop_d;
            pend_fence_q <= pend_fence_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            ivalid_q     <= ivalid_d;
            fence_q      <= fence_d;
        end
    end

    assign ifu_araddr  = araddr_q;
    assign ifu_arvalid = arvalid_q;
    assign ifu_rready  = rready_q;
    assign fence_i     = fence_q;
    assign inst_valid  = ivalid_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign inst_fault  = fault_q;

endmodule

// File: tb/tb_ysyx_25040129_ifu.sv
// Scoreboard bench for the IFU: a small ICACHE stub answers reads, monitors
// compare every AR address and every accepted instruction against queued expectations.
module tb_ysyx_25040129_ifu;
    localparam logic [31:0] RESET_PC = 32'h3000_0000;
    localparam logic [31:0] POISON   = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid;
    logic        ifu_rready;
    logic        fence_i;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fence_i_req;

    always #5 clk = ~clk;

    ysyx_25040129_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid),
        .ifu_rready(ifu_rready), .fence_i(fence_i),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .inst_fault(inst_fault),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fence_i_req(fence_i_req)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_ar[$];
    exp_t        exp_inst[$];
    exp_t        got;
    int          fence_cnt = 0;
    logic        outs = 1'b0;

    // ICACHE stub controls
    int          r_delay = 0;
    int          cnt = 0;
    logic [1:0]  resp_val = 2'b00;
    logic [31:0] ovr_addr = 32'hFFFF_FFFF;
    logic [31:0] ovr_data = 32'h0;
    logic [31:0] req_addr;

    assign ifu_arready = 1'b1;
    assign ifu_rresp   = resp_val;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        return (a == ovr_addr) ? ovr_data : mem(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // ICACHE stub: rvalid r_delay+1 cycles after the AR handshake
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ifu_rvalid <= 1'b0;
            ifu_rdata  <= 32'h0;
            cnt        <= 0;
        end else begin
            if (ifu_rvalid && ifu_rready) ifu_rvalid <= 1'b0;
            if (ifu_arvalid && ifu_arready) begin
                req_addr <= ifu_araddr;
                if (r_delay == 0) begin
                    ifu_rvalid <= 1'b1;
                    ifu_rdata  <= rd(ifu_araddr);
                end else begin
                    cnt <= r_delay;
                end
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    ifu_rvalid <= 1'b1;
                    ifu_rdata  <= rd(req_addr);
                end
            end
        end
    end

    // Monitor: sampled on the falling edge, away from DUT updates
    always @(negedge clk) begin
        if (rst) begin
            outs = 1'b0;
        end else begin
            if (ifu_arvalid || ifu_rready)
                chk("ar_r_exclusive", 32'(ifu_arvalid && ifu_rready), 32'h0);
            if (fence_i) begin
                fence_cnt++;
                chk("fence_arvalid", 32'(ifu_arvalid), 32'h0);
                chk("fence_outstanding", 32'(outs), 32'h0);
            end
            if (ifu_arvalid && ifu_arready) begin
                if (exp_ar.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_ar: got %h expected no request", ifu_araddr);
                end else begin
                    chk("araddr", ifu_araddr, exp_ar.pop_front());
                end
                outs = 1'b1;
            end
            if (ifu_rvalid && ifu_rready) outs = 1'b0;
            if (inst_valid) chk("poison_hidden", 32'(inst == POISON), 32'h0);
            if (inst_valid && inst_ready && !redirect_valid) begin
                if (exp_inst.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_inst: got pc %h expected none", inst_pc);
                end else begin
                    got = exp_inst.pop_front();
                    chk("inst_pc", inst_pc, got.pc);
                    chk("inst", inst, got.data);
                    chk("inst_fault", 32'(inst_fault), 32'(got.fault));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_araddr"}, ifu_araddr, 32'h0);
        chk({nm, "_arvalid"}, 32'(ifu_arvalid), 32'h0);
        chk({nm, "_rready"}, 32'(ifu_rready), 32'h0);
        chk({nm, "_fence_i"}, 32'(fence_i), 32'h0);
        chk({nm, "_inst_valid"}, 32'(inst_valid), 32'h0);
        chk({nm, "_inst"}, inst, 32'h0);
        chk({nm, "_inst_pc"}, inst_pc, 32'h0);
        chk({nm, "_inst_fault"}, 32'(inst_fault), 32'h0);
    endtask

    // sel 0: wait for inst_valid, sel 1: wait for ifu_rready
    task automatic wait_for(input int sel);
        int n = 0;
        while (!(sel == 0 ? inst_valid : ifu_rready)) begin
            tick();
            n++;
            if (n > 100) begin
                vectors++;
                miscompares++;
                $display("FAIL timeout: got no %s expected within 100 cycles",
                         sel == 0 ? "inst_valid" : "ifu_rready");
                return;
            end
        end
    endtask

    task automatic take(input logic [31:0] pc, input logic [31:0] data, input logic fault);
        logic [31:0] nxt;
        nxt = pc + 32'd4;
        exp_inst.push_back('{pc: pc, data: data, fault: fault});
        if (nxt[1:0] == 2'b00) exp_ar.push_back(nxt);
        wait_for(0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc, input logic fence, input logic rdy);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        fence_i_req    = fence;
        inst_ready     = rdy;
        tick();
        redirect_valid = 1'b0;
        fence_i_req    = 1'b0;
        inst_ready     = 1'b0;
    endtask

    initial begin
        int f0;
        int n;
        rst = 1'b1;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        fence_i_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");

        // Sequential fetch with the IDU always ready, plus hit-path latency
        for (int i = 0; i < 4; i++) exp_ar.push_back(RESET_PC + 32'(4 * i));
        for (int i = 0; i < 3; i++)
            exp_inst.push_back('{pc: RESET_PC + 32'(4 * i), data: mem(RESET_PC + 32'(4 * i)), fault: 1'b0});
        inst_ready = 1'b1;
        rst = 1'b0;
        tick();
        chk("lat_arvalid", 32'(ifu_arvalid), 32'h1);
        chk("lat_araddr", ifu_araddr, RESET_PC);
        tick();
        chk("lat_rready", 32'(ifu_rready), 32'h1);
        tick();
        chk("lat_inst_valid", 32'(inst_valid), 32'h1);
        n = 0;
        while (exp_inst.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("seq_drained", 32'(exp_inst.size()), 32'h0);
        inst_ready = 1'b0;

        // IDU stall: payload held, no new request
        wait_for(0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(inst_valid), 32'h1);
            chk("stall_inst", inst, mem(32'h3000_000C));
            chk("stall_pc", inst_pc, 32'h3000_000C);
            chk("stall_arvalid", 32'(ifu_arvalid), 32'h0);
            tick();
        end
        take(32'h3000_000C, mem(32'h3000_000C), 1'b0);

        // Redirect while waiting on a slow response carrying a poison word
        ovr_addr = 32'h3000_0014;
        ovr_data = POISON;
        take(32'h3000_0010, mem(32'h3000_0010), 1'b0);
        r_delay = 4;
        wait_for(1);
        exp_ar.push_back(32'h8000_0100);
        redirect(32'h8000_0100, 1'b0, 1'b0);
        r_delay = 0;
        take(32'h8000_0100, mem(32'h8000_0100), 1'b0);

        // Redirect + fence.i in OUT, same cycle as inst_ready
        wait_for(0);
        f0 = fence_cnt;
        exp_ar.push_back(32'h8000_0200);
        redirect(32'h8000_0200, 1'b1, 1'b1);
        take(32'h8000_0200, mem(32'h8000_0200), 1'b0);
        chk("fence_once_out", 32'(fence_cnt - f0), 32'h1);

        // Redirect + fence.i while a read is outstanding
        r_delay = 2;
        f0 = fence_cnt;
        wait_for(1);
        exp_ar.push_back(32'h8000_0300);
        redirect(32'h8000_0300, 1'b1, 1'b0);
        r_delay = 0;
        take(32'h8000_0300, mem(32'h8000_0300), 1'b0);
        chk("fence_once_wait", 32'(fence_cnt - f0), 32'h1);

        // Misaligned target faults without a bus request; error response faults
        wait_for(0);
        redirect(32'h8000_0002, 1'b0, 1'b0);
        take(32'h8000_0002, 32'h0, 1'b1);
        wait_for(0);
        chk("misalign2_pc", inst_pc, 32'h8000_0006);
        chk("misalign2_fault", 32'(inst_fault), 32'h1);
        exp_ar.push_back(32'h8000_0400);
        redirect(32'h8000_0400, 1'b0, 1'b0);
        resp_val = 2'b10;
        take(32'h8000_0400, mem(32'h8000_0400), 1'b1);
        resp_val = 2'b00;

        // PC wrap, then reset in the middle of a read
        wait_for(0);
        exp_ar.push_back(32'hFFFF_FFFC);
        redirect(32'hFFFF_FFFC, 1'b0, 1'b0);
        take(32'hFFFF_FFFC, mem(32'hFFFF_FFFC), 1'b0);
        r_delay = 3;
        wait_for(1);
        rst = 1'b1;
        #1;
        check_zero("rst_mid_wait");
        tick();
        r_delay = 0;
        exp_ar.push_back(RESET_PC);
        rst = 1'b0;
        take(RESET_PC, mem(RESET_PC), 1'b0);
        n = 0;
        while (exp_ar.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("ar_queue_empty", 32'(exp_ar.size()), 32'h0);
        chk("inst_queue_empty", 32'(exp_inst.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
